// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the BCD up/down counter: seven-segment patterns
// (active-low {g,f,e,d,c,b,a}) and elaboration-time helpers.
package bcd_updown_counter_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic int bcd_w(input int digits);
      return 4 * digits;
   endfunction

   // Packs up to four decimal digits, digit 0 in the LSBs.
   function automatic logic [15:0] to_bcd(input int value);
      logic [15:0] r;
      int          v;
      r = '0;
      v = value;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_updown_counter_seg7_decoder.sv
// Single-digit BCD to active-low seven-segment decoder with forced blank.
module seg7_decoder
   import bcd_updown_counter_pkg::*;
(
   input  logic [3:0] i_nibble,
   input  logic       i_blank,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable terminal count, validated
// parallel load, wrap/saturate mode and per-digit seven-segment outputs.
module bcd_updown_counter
   import bcd_updown_counter_pkg::*;
#(
   parameter int DIGITS   = 2,
   parameter int MAX      = 99,
   parameter bit SATURATE = 1'b0,
   parameter bit LZ_BLANK = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        up,
   input  logic                        load,
   input  logic [bcd_w(DIGITS)-1:0]    load_val,
   output logic [bcd_w(DIGITS)-1:0]    bcd,
   output logic [7*DIGITS-1:0]         hex,
   output logic                        tc,
   output logic                        wrap,
   output logic                        load_err
);

   localparam int              W         = bcd_w(DIGITS);
   localparam logic [15:0]     MAX_BCD16 = to_bcd(MAX);
   localparam logic [W-1:0]    MAX_BCD   = MAX_BCD16[W-1:0];

   logic [W-1:0]      r_bcd;
   logic              r_wrap;
   logic              r_load_err;
   logic [W-1:0]      w_inc;
   logic [W-1:0]      w_dec;
   logic              w_nib_ok;
   logic              w_load_ok;
   logic              w_at_max;
   logic              w_at_zero;
   logic [DIGITS-1:0] w_blank;

   always_comb begin
      logic c;
      logic b;
      w_inc = r_bcd;
      w_dec = r_bcd;
      c     = 1'b1;
      b     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r_bcd[4*i +: 4] == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
               c               = 1'b0;
            end
         end
         if (b) begin
            if (r_bcd[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
               b               = 1'b0;
            end
         end
      end
   end

   // With every nibble a valid digit, packed BCD orders the same as its decimal value.
   always_comb begin
      w_nib_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) w_nib_ok = 1'b0;
      end
   end

   assign w_load_ok = w_nib_ok && (load_val <= MAX_BCD);
   assign w_at_max  = (r_bcd == MAX_BCD);
   assign w_at_zero = (r_bcd == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_bcd      <= '0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
         if (load) begin
            if (w_load_ok) r_bcd      <= load_val;
            else           r_load_err <= 1'b1;
         end else if (en) begin
            if (up) begin
               if (!w_at_max) begin
                  r_bcd <= w_inc;
               end else if (!SATURATE) begin
                  r_bcd  <= '0;
                  r_wrap <= 1'b1;
               end
            end else begin
               if (!w_at_zero) begin
                  r_bcd <= w_dec;
               end else if (!SATURATE) begin
                  r_bcd  <= MAX_BCD;
                  r_wrap <= 1'b1;
               end
            end
         end
      end
   end

   assign bcd      = r_bcd;
   assign wrap     = r_wrap;
   assign load_err = r_load_err;
   assign tc       = en & ((up & w_at_max) | (~up & w_at_zero));

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_blank[i] = LZ_BLANK && (i != 0) && (r_bcd[W-1:4*i] == '0);

      seg7_decoder u_dec (
         .i_nibble (r_bcd[4*i +: 4]),
         .i_blank  (w_blank[i]),
         .o_seg    (hex[7*i +: 7])
      );
   end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Four counter configurations driven in parallel and compared every cycle
// against a decimal-integer reference model.
module tb_bcd_updown_counter;

   localparam int         NDUT    = 4;
   localparam int         DIG [4] = '{2, 2, 2, 3};
   localparam int         MAXV[4] = '{99, 59, 59, 999};
   localparam bit         SATV[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   localparam bit         LZV [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [6:0] SEGT[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        up  = 1'b0;
   logic        load = 1'b0;
   logic [11:0] lv  = '0;

   logic [11:0] bcd_o  [NDUT];
   logic [20:0] hex_o  [NDUT];
   logic        tc_o   [NDUT];
   logic        wrap_o [NDUT];
   logic        lerr_o [NDUT];

   int   cnt [NDUT];
   logic ew  [NDUT];
   logic el  [NDUT];
   int   nvec  = 0;
   int   nerr  = 0;
   bit   armed = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int D = (g == 3) ? 3 : 2;
      localparam int M = (g == 0) ? 99 : ((g == 3) ? 999 : 59);
      logic [4*D-1:0] b;
      logic [7*D-1:0] h;
      logic           t, w, e;

      bcd_updown_counter #(
         .DIGITS   (D),
         .MAX      (M),
         .SATURATE (g == 2),
         .LZ_BLANK (g == 3)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .up       (up),
         .load     (load),
         .load_val (lv[4*D-1:0]),
         .bcd      (b),
         .hex      (h),
         .tc       (t),
         .wrap     (w),
         .load_err (e)
      );

      assign bcd_o[g]  = 12'(b);
      assign hex_o[g]  = 21'(h);
      assign tc_o[g]   = t;
      assign wrap_o[g] = w;
      assign lerr_o[g] = e;
   end

   function automatic logic [11:0] tobcd(input int v);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      return r;
   endfunction

   function automatic logic [20:0] exp_hex(input int g);
      logic [20:0] r;
      r = '0;
      for (int i = 0; i < DIG[g]; i++) begin
         if (LZV[g] && i > 0 && cnt[g] < 10 ** i) r[7*i +: 7] = 7'h7F;
         else                                     r[7*i +: 7] = SEGT[(cnt[g] / (10 ** i)) % 10];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int g = 0; g < NDUT; g++) begin
         if (!rst) begin
            cnt[g] = 0;
            ew[g]  = 1'b0;
            el[g]  = 1'b0;
         end else begin
            ew[g] = 1'b0;
            el[g] = 1'b0;
            if (load) begin
               bit ok;
               int val;
               ok  = 1'b1;
               val = 0;
               for (int i = 0; i < DIG[g]; i++) begin
                  if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
                  val += int'(lv[4*i +: 4]) * (10 ** i);
               end
               if (ok && val <= MAXV[g]) cnt[g] = val;
               else                      el[g]  = 1'b1;
            end else if (en) begin
               if (up) begin
                  if (cnt[g] < MAXV[g]) cnt[g]++;
                  else if (!SATV[g]) begin cnt[g] = 0; ew[g] = 1'b1; end
               end else begin
                  if (cnt[g] > 0) cnt[g]--;
                  else if (!SATV[g]) begin cnt[g] = MAXV[g]; ew[g] = 1'b1; end
               end
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic u,
                       input logic l, input logic [11:0] v);
      rst = r; en = e; up = u; load = l; lv = v;
      #1;
      if (armed) begin
         for (int g = 0; g < NDUT; g++)
            chk($sformatf("tc%0d", g), 21'(tc_o[g]),
                21'(en && ((up && cnt[g] == MAXV[g]) || (!up && cnt[g] == 0))));
      end
      @(posedge clk);
      model_edge();
      armed = 1'b1;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         chk($sformatf("bcd%0d", g),  21'(bcd_o[g]),  21'(tobcd(cnt[g])));
         chk($sformatf("hex%0d", g),  hex_o[g],       exp_hex(g));
         chk($sformatf("wrap%0d", g), 21'(wrap_o[g]), 21'(ew[g]));
         chk($sformatf("lerr%0d", g), 21'(lerr_o[g]), 21'(el[g]));
      end
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      chk("rst_bcd0", 21'(bcd_o[0]), 21'h0);
      chk("rst_hex0", hex_o[0], 21'({7'h40, 7'h40}));
      chk("rst_hex3", hex_o[3], {7'h7F, 7'h7F, 7'h40});

      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      chk("inc10_bcd", 21'(bcd_o[0]), 21'h010);
      chk("inc10_hex", hex_o[0], 21'({7'h79, 7'h40}));

      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h098);
      step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      chk("wrapup_99", 21'(bcd_o[0]), 21'h099);
      step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      chk("wrapup_00", 21'(bcd_o[0]), 21'h000);
      chk("wrapup_pulse", 21'(wrap_o[0]), 21'h1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      chk("wrapup_clear", 21'(wrap_o[0]), 21'h0);

      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
      step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      chk("mod59_down", 21'(bcd_o[1]), 21'h059);
      chk("mod59_wrap", 21'(wrap_o[1]), 21'h1);
      chk("sat_hold", 21'(bcd_o[2]), 21'h000);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
      chk("sat_hold3", 21'(bcd_o[2]), 21'h000);
      chk("sat_nowrap", 21'(wrap_o[2]), 21'h0);

      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h03A);
      chk("bad_nib_bcd", 21'(bcd_o[1]), 21'h056);
      chk("bad_nib_err", 21'(lerr_o[1]), 21'h1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h060);
      chk("over_max_bcd", 21'(bcd_o[1]), 21'h056);
      chk("over_max_err", 21'(lerr_o[1]), 21'h1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 12'h025);
      chk("load_en", 21'(bcd_o[1]), 21'h025);
      chk("load_en_noerr", 21'(lerr_o[1]), 21'h0);

      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h007);
      chk("lz_007", hex_o[3], {7'h7F, 7'h7F, 7'h78});
      step(1'b1, 1'b0, 1'b0, 1'b1, 12'h100);
      chk("lz_100", hex_o[3], {7'h79, 7'h40, 7'h40});
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
      step(1'b0, 1'b1, 1'b1, 1'b1, 12'h555);
      chk("rst_mid", 21'(bcd_o[3]), 21'h000);

      for (int n = 0; n < 400; n++) begin
         logic [11:0] v;
         if ($urandom % 2 == 0) v = tobcd(int'($urandom_range(0, 999)));
         else                   v = 12'($urandom);
         step(($urandom % 40) != 0, ($urandom % 4) != 0, 1'($urandom),
              ($urandom % 4) == 0, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with programmable modulo, parallel load, wrap/saturate mode and per-digit active-low seven-segment outputs. It replaces the fixed 8-bit binary up/down counter and its hex decoders in the DE1 lab designs: counting is decimal rather than hexadecimal, and the terminal value is programmable. Switches drive `en` and `up`, a debounced key drives `clk`, and the `hex` bus drives HEX0..HEX(DIGITS-1) directly.

## Interface
- `DIGITS`, 2: number of BCD digits, 1..4.
- `MAX`, 99: terminal count in decimal, 0 < MAX ≤ 10^DIGITS−1.
- `SATURATE`, 0: 0 = wrap at the limits; 1 = hold at the limits.
- `LZ_BLANK`, 0: 1 = blank leading zero digits. Digit 0 is never blanked.

Ports:
- `clk` input 1: rising-edge clock. This is the only clock.
- `rst` input 1: reset, synchronous and active-low.
- `en` input 1: count enable.
- `up` input 1: direction. 1 = up, 0 = down.
- `load` input 1: parallel load strobe.
- `load_val` input 4*DIGITS: BCD load value. Digit 0 is in bits [3:0].
- `bcd` output 4*DIGITS: registered count, packed BCD, digit 0 in the LSBs.
- `hex` output 7*DIGITS: active-low segments {g,f,e,d,c,b,a}. Digit i is in bits [7i+6:7i].
- `tc` output 1: combinational terminal-count flag.
- `wrap` output 1: registered one-cycle pulse.
- `load_err` output 1: registered one-cycle pulse.

## Operation
- Update priority on each rising edge of `clk`: `rst`==0, then `load`, then `en`, then hold.
- Reset, when `rst`==0 at the edge:
  - `bcd`=0, `wrap`=0, `load_err`=0.
  - `hex` then shows "0" on every digit. With LZ_BLANK=1, digit 0 shows "0" and the other digits are blank (7'h7F).
- Load, when `load`=1:
  - `load_val` is accepted only if every nibble is ≤9 and its decimal value is ≤MAX. An accepted value is written to `bcd`.
  - Otherwise `bcd` is unchanged and `load_err` is 1 for the next cycle.
  - `load` overrides `en` in the same cycle. No count step occurs in a load cycle.
- Count up, when `en`=1 and `up`=1:
  - Decimal increment with ripple carry between digits: a digit at 9 becomes 0 and carries into the next digit.
  - At `bcd`==MAX with SATURATE=0: next value is 0 and `wrap` pulses.
  - At `bcd`==MAX with SATURATE=1: the value holds and there is no `wrap` pulse.
- Count down, when `en`=1 and `up`=0:
  - Decimal decrement with borrow between digits: a digit at 0 becomes 9 and borrows from the next digit.
  - At `bcd`==0 with SATURATE=0: next value is MAX and `wrap` pulses.
  - At `bcd`==0 with SATURATE=1: the value holds and there is no `wrap` pulse.
- `tc` = `en` & ((`up` & `bcd`==MAX) | (~`up` & `bcd`==0)). `tc` is independent of `load` and is intended for cascading counters.
- `wrap` and `load_err` are 1 for exactly one cycle after the triggering edge, otherwise 0.
- Decoder, applied per digit:
  - Values 0–9 use the standard active-low patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any other nibble gives blank, 7'h7F. This is unreachable by construction.
- Leading-zero blanking (LZ_BLANK=1): digit i (i>0) is blank when it and all higher digits are 0.

## Timing
- `bcd`, `wrap` and `load_err` are registered. They change only on a rising edge of `clk`.
- Latency from `en`/`load`/`rst` at an edge to the new `bcd` is 1 cycle.
- `hex` and `tc` are combinational from `bcd` and the inputs, with zero additional latency.
- Reset mid-count takes effect at the next edge and overrides `load`/`en` in that cycle. A `wrap` or `load_err` pulse pending from the previous cycle is cleared.
- Any `load`/`en`/`up` combination is legal on any cycle.

## Structure
- Shared package holds:
  - the seven-segment constants SEG_0..SEG_9 and SEG_BLANK;
  - a function converting a decimal integer to packed BCD, used to derive MAX_BCD at elaboration;
  - a width helper equal to 4*DIGITS.
- Sub-module `seg7_decoder`:
  - Ports: 4-bit nibble and `blank` inputs, 7-bit segment output.
  - Instantiated DIGITS times in a generate loop.
- The counter core, load validation and the flags live in the top module.

## Test plan
- Reset and increment (DIGITS=2, MAX=99): `rst`=0 for one edge, then `en`=1 and `up`=1 for 10 edges. Required:
  - `bcd`=8'h00 after reset, then 8'h10 after the 10 edges;
  - `hex`={7'h79,7'h40};
  - `wrap` never asserted.
- Wrap up: load 8'h98, then 2 up edges. Required:
  - `bcd` goes 8'h99, then 8'h00;
  - `tc`=1 while `bcd` is 8'h99;
  - `wrap`=1 for exactly one cycle after the 99→00 edge.
- Modulo and down count (MAX=59): load 8'h00, then 1 down edge. Required: `bcd`=8'h59 and `wrap` pulses.
- Saturation (MAX=59, SATURATE=1): 3 further down edges from 8'h00. Required: `bcd` stays 8'h00 and `wrap` stays 0.
- Invalid load, MAX=59:
  - `load_val`=8'h3A. Required: `bcd` unchanged and `load_err` pulses once.
  - `load_val`=8'h60. Required: same response.
  - `load`=1 and `en`=1 in the same cycle with 8'h25. Required: `bcd`=8'h25 exactly, with no count step.
- Leading-zero blanking (DIGITS=3, LZ_BLANK=1):
  - `bcd`=12'h007. Required: `hex`={7'h7F,7'h7F,7'h78}.
  - `bcd`=12'h100. Required: `hex`={7'h79,7'h40,7'h40}.
  - `rst`=0 asserted mid-count. Required: `bcd`=0 on the next edge.
